// File: rtl/rs232_packet_master.sv
// Host-side RS232 register-access initiator.
// Builds the 8-byte command frame (STX, addr nibbles, data nibbles, R/W, CS, ETX),
// pushes it through the byte transmitter one byte at a time and, for reads,
// parses the 4-byte response frame (STX, hi nibble, lo nibble, ETX).
module rs232_packet_master #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    input  logic       tx_done,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Last timer value before expiry: leaving on this cycle puts DONE exactly
    // TIMEOUT_CYCLES cycles after the first RSP_STX cycle.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_FRAMING = 2'b10;
    localparam logic [1:0] ERR_CS_COLL = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK,
        S_SEND,
        S_WAIT_TX,
        S_RSP_STX,
        S_RSP_HI,
        S_RSP_LO,
        S_RSP_ETX,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      idx_reg, idx_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [3:0]      hi_reg, hi_next;
    logic [3:0]      lo_reg, lo_next;
    logic [7:0]      rdata_reg, rdata_next;
    logic [1:0]      err_reg, err_next;
    logic            load_en;

    logic [7:0]      frame_reg [8];
    logic [7:0]      load_byte [8];
    logic [7:0]      load_cs;
    logic [7:0]      frame_cs;
    logic            frame_is_write;

    // Checksum over bytes 0..5 of the frame being loaded (mod 256).
    assign load_cs = STX
                   + {4'h3, cmd_addr[7:4]}
                   + {4'h3, cmd_addr[3:0]}
                   + {4'h3, cmd_wdata[7:4]}
                   + {4'h3, cmd_wdata[3:0]}
                   + {7'h18, cmd_write};

    // Frame image presented to the buffer at command acceptance.
    always_comb begin
        load_byte[0] = STX;
        load_byte[1] = {4'h3, cmd_addr[7:4]};
        load_byte[2] = {4'h3, cmd_addr[3:0]};
        load_byte[3] = {4'h3, cmd_wdata[7:4]};
        load_byte[4] = {4'h3, cmd_wdata[3:0]};
        load_byte[5] = {7'h18, cmd_write};
        load_byte[6] = load_cs;
        load_byte[7] = ETX;
    end

    // The R/W byte doubles as the latched command direction.
    assign frame_cs       = frame_reg[6];
    assign frame_is_write = frame_reg[5][0];

    // Frame buffer: captured once per accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) frame_reg[i] <= 8'h00;
        end else if (load_en) begin
            for (int i = 0; i < 8; i++) frame_reg[i] <= load_byte[i];
        end
    end

    // State, byte index, response timer, nibble and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            idx_reg   <= 3'd0;
            timer_reg <= '0;
            hi_reg    <= 4'h0;
            lo_reg    <= 4'h0;
            rdata_reg <= 8'h00;
            err_reg   <= ERR_OK;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            timer_reg <= timer_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic; result registers only change on the way into DONE.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        timer_next = timer_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        load_en    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    load_en    = 1'b1;
                    state_next = S_CHK;
                end
            end

            S_CHK: begin
                if (frame_cs == STX || frame_cs == ETX) begin
                    state_next = S_DONE;
                    rdata_next = 8'h00;
                    err_next   = ERR_CS_COLL;
                end else begin
                    idx_next   = 3'd0;
                    state_next = S_SEND;
                end
            end

            S_SEND: begin
                state_next = S_WAIT_TX;
            end

            S_WAIT_TX: begin
                if (tx_done) begin
                    if (idx_reg != 3'd7) begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = S_SEND;
                    end else if (frame_is_write) begin
                        state_next = S_DONE;
                        rdata_next = 8'h00;
                        err_next   = ERR_OK;
                    end else begin
                        timer_next = '0;
                        state_next = S_RSP_STX;
                    end
                end
            end

            S_RSP_STX, S_RSP_HI, S_RSP_LO, S_RSP_ETX: begin
                timer_next = timer_reg + 1'b1;
                if (timer_reg == TIMER_LAST) begin
                    // Expiry wins over a byte arriving in the same cycle.
                    state_next = S_DONE;
                    rdata_next = 8'h00;
                    err_next   = ERR_TIMEOUT;
                end else if (rx_valid) begin
                    if (state_reg == S_RSP_STX) begin
                        if (rx_byte == STX) state_next = S_RSP_HI;
                    end else if (rx_byte == STX) begin
                        // A fresh STX mid-frame restarts the response parse.
                        state_next = S_RSP_HI;
                    end else if (state_reg == S_RSP_HI && rx_byte[7:4] == 4'h3) begin
                        hi_next    = rx_byte[3:0];
                        state_next = S_RSP_LO;
                    end else if (state_reg == S_RSP_LO && rx_byte[7:4] == 4'h3) begin
                        lo_next    = rx_byte[3:0];
                        state_next = S_RSP_ETX;
                    end else if (state_reg == S_RSP_ETX && rx_byte == ETX) begin
                        state_next = S_DONE;
                        rdata_next = {hi_reg, lo_reg};
                        err_next   = ERR_OK;
                    end else begin
                        state_next = S_DONE;
                        rdata_next = 8'h00;
                        err_next   = ERR_FRAMING;
                    end
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake and transmitter outputs decoded from the current state.
    assign cmd_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign tx_start  = (state_reg == S_SEND);
    assign tx_byte   = (state_reg == S_SEND || state_reg == S_WAIT_TX) ? frame_reg[idx_reg] : 8'h00;
    assign rsp_valid = (state_reg == S_DONE);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_rs232_packet_master.sv
// Self-checking bench for rs232_packet_master: a byte-transmitter stand-in
// acknowledges each tx_start after 4 cycles, a scoreboard holds the expected
// frame bytes and responses, and response frames are injected on rx.
module tb_rs232_packet_master;

    localparam int TO = 100;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_done;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       busy;

    typedef struct {
        logic [7:0] rdata;
        logic [1:0] err;
    } rsp_t;
    typedef logic [7:0] bq_t [$];

    logic [7:0] tx_q [$];
    rsp_t       rsp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    rs232_packet_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .tx_byte   (tx_byte),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference frame byte i for a command.
    function automatic logic [7:0] model_byte(input logic wr, input logic [7:0] a,
                                              input logic [7:0] d, input int i);
        logic [7:0] f [8];
        f[0] = 8'h02;
        f[1] = {4'h3, a[7:4]};
        f[2] = {4'h3, a[3:0]};
        f[3] = {4'h3, d[7:4]};
        f[4] = {4'h3, d[3:0]};
        f[5] = wr ? 8'h31 : 8'h30;
        f[6] = f[0] + f[1] + f[2] + f[3] + f[4] + f[5];
        f[7] = 8'h03;
        return f[i];
    endfunction

    task automatic expect_rsp(input logic [7:0] rd, input logic [1:0] er);
        rsp_t r;
        r.rdata = rd;
        r.err   = er;
        rsp_q.push_back(r);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_tx_start"},  tx_start,  0);
        check({tag, "_tx_byte"},   tx_byte,   0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_err"},   rsp_err,   0);
    endtask

    // Present one command for a single cycle; returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
        check("idle_ready", cmd_ready, 1);
        check("idle_busy",  busy,      0);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) tx_q.push_back(model_byte(wr, a, d, i));
        $display("cmd %s addr=%02h wdata=%02h cs=%02h", wr ? "WR" : "RD", a, d, model_byte(wr, a, d, 6));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("accepted_busy", busy, 1);
    endtask

    // Transmitter stand-in: check each byte, ack with tx_done 4 cycles after tx_start.
    task automatic serve_tx(input int n, input int first_lat);
        int         waited;
        logic [7:0] exp_b;
        for (int k = 0; k < n; k++) begin
            waited = 0;
            while (!tx_start && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            if (!tx_start) begin
                check("tx_start_seen", 0, 1);
                return;
            end
            check(k == 0 ? "send_latency" : "byte_gap", waited, k == 0 ? first_lat : 0);
            exp_b = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
            check("tx_byte", tx_byte, exp_b);
            $display("tx byte %0d: %02h (exp %02h)", k, tx_byte, exp_b);
            @(negedge clk);
            @(negedge clk);
            check("tx_hold", tx_byte, exp_b);
            check("tx_start_pulse", tx_start, 0);
            @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    task automatic rx_frame(input bq_t bs);
        foreach (bs[i]) begin
            if (i > 0) @(negedge clk);
            rx_byte  = bs[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    // Wait (bounded) for rsp_valid and compare against the scoreboard head.
    task automatic wait_rsp(input int max, output int waited);
        rsp_t r;
        waited = 0;
        while (!rsp_valid && waited < max) begin
            @(negedge clk);
            waited++;
        end
        if (!rsp_valid) begin
            check("rsp_valid_seen", 0, 1);
            return;
        end
        if (rsp_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
            return;
        end
        r = rsp_q.pop_front();
        check("rsp_rdata", rsp_rdata, r.rdata);
        check("rsp_err",   rsp_err,   r.err);
        $display("rsp rdata=%02h err=%0d (exp %02h/%0d) after %0d cycles",
                 rsp_rdata, rsp_err, r.rdata, r.err, waited);
        @(negedge clk);
        check("rsp_one_cycle", rsp_valid, 0);
        check("rsp_hold", rsp_rdata, r.rdata);
    endtask

    initial begin
        int  w;
        bq_t bq;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        tx_done   = 1'b0;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Write: full frame out, completion the cycle after the 8th tx_done.
        issue(1'b1, 8'h5A, 8'hC3);
        expect_rsp(8'h00, 2'b00);
        serve_tx(8, 1);
        wait_rsp(5, w);
        check("write_latency", w, 0);

        // Read with leading junk before STX.
        issue(1'b0, 8'h10, 8'h00);
        serve_tx(8, 1);
        expect_rsp(8'h7E, 2'b00);
        bq = '{8'h55, 8'h02, 8'h37, 8'h3E, 8'h03};
        rx_frame(bq);
        wait_rsp(3, w);
        check("read_latency", w, 0);

        // Checksum collision, cmd_valid held: two back-to-back collisions.
        cmd_write = 1'b1;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h0F;
        cmd_valid = 1'b1;
        $display("cmd WR addr=00 wdata=0F cs=%02h (held valid)", model_byte(1'b1, 8'h00, 8'h0F, 6));
        @(negedge clk);
        check("coll_chk_tx_start", tx_start, 0);
        check("coll_chk_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("coll_rsp_valid", rsp_valid, 1);
        check("coll_rsp_err", rsp_err, 2'b11);
        check("coll_rsp_rdata", rsp_rdata, 0);
        check("coll_tx_start", tx_start, 0);
        @(negedge clk);
        check("coll_ready_t3", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("coll2_accepted", busy, 1);
        check("coll2_tx_start", tx_start, 0);
        @(negedge clk);
        check("coll2_rsp_valid", rsp_valid, 1);
        check("coll2_rsp_err", rsp_err, 2'b11);
        @(negedge clk);
        check("coll2_rsp_one_cycle", rsp_valid, 0);

        // Timeout: no response at all.
        issue(1'b0, 8'h21, 8'h00);
        serve_tx(8, 1);
        expect_rsp(8'h00, 2'b01);
        wait_rsp(3 * TO, w);
        check("timeout_latency", w, TO);

        // Framing error on illegal low-nibble byte.
        issue(1'b0, 8'h10, 8'h00);
        serve_tx(8, 1);
        expect_rsp(8'h00, 2'b10);
        bq = '{8'h02, 8'h37, 8'h41};
        rx_frame(bq);
        wait_rsp(3, w);
        check("framing_latency", w, 0);

        // Mid-frame STX resynchronises.
        issue(1'b0, 8'h10, 8'h00);
        serve_tx(8, 1);
        expect_rsp(8'h45, 2'b00);
        bq = '{8'h02, 8'h37, 8'h02, 8'h34, 8'h35, 8'h03};
        rx_frame(bq);
        wait_rsp(3, w);
        check("resync_latency", w, 0);

        // Reset during byte 4 of a write.
        issue(1'b1, 8'h5A, 8'hC3);
        serve_tx(3, 1);
        w = 0;
        while (!tx_start && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("byte4_tx_start", tx_start, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        tx_q.delete();
        repeat (2) @(negedge clk);
        check("reset_no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Read after reset completes normally.
        issue(1'b0, 8'h3C, 8'hA5);
        serve_tx(8, 1);
        expect_rsp(8'hA5, 2'b00);
        bq = '{8'h02, 8'h3A, 8'h35, 8'h03};
        rx_frame(bq);
        wait_rsp(3, w);
        check("post_reset_latency", w, 0);

        check("tx_q_drained", tx_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
